// File: rtl/adc_spi_responder.sv
// adc_spi_responder: ADC emulator answering the adc_driver serial command/sample frame
// Optional feature: define ADC_EMU_RAMP_EN to replace ch_data_i with per-channel ramp counters.
module adc_spi_responder #(
    parameter int NUM_CH         = 8,
    parameter int DATA_W         = 10,
    parameter int DATA_LSB_FIRST = 1,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     sclk_i,
    input  logic                     cs_i,
    input  logic                     din_i,
    output logic                     dout_o,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    output logic                     busy_o,
    output logic                     frame_done_o,
    output logic                     frame_abort_o,
    output logic [3:0]               cfg_o,
    output logic [DATA_W-1:0]        sample_o
);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_W);

    typedef enum logic [2:0] {IDLE, CMD, SAMPLE, NULLB, DATA, DONE} state_t;

    state_t state, state_n;
    logic [SYNC_STAGES-1:0] sclk_q, cs_q, din_q;
    logic sclk_d, sclk_s, cs_s, din_s, rise, fall;
    logic [2:0] cmd_cnt, cmd_cnt_n, cmd_sr, cmd_sr_n, ch_n;
    logic [BW-1:0] bit_cnt, bit_cnt_n;
    logic sam, sam_n, dout_n, done_n, abort_n;
    logic [3:0] cfg_n;
    logic [DATA_W-1:0] sample_n, sel_sample;
    logic [NUM_CH*DATA_W-1:0] src, src_sh;

    // Synchronize the asynchronous link signals and keep one sclk history bit for edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sclk_q <= '0;
            cs_q   <= '1;
            din_q  <= '0;
            sclk_d <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_i};
            din_q  <= {din_q[SYNC_STAGES-2:0], din_i};
            sclk_d <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign cs_s   = cs_q[SYNC_STAGES-1];
    assign din_s  = din_q[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_d;
    assign fall   = ~sclk_s & sclk_d;
    assign busy_o = (state != IDLE);

`ifdef ADC_EMU_RAMP_EN
    logic [NUM_CH*DATA_W-1:0] ramp_q;
    logic unused_ch_data;
    assign unused_ch_data = ^ch_data_i;
    assign src = ramp_q;

    // Advance the ramp of the channel just read once its frame completes
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            ramp_q <= '0;
        else if (frame_done_o && int'(cfg_o[2:0]) < NUM_CH)
            ramp_q[int'(cfg_o[2:0])*DATA_W +: DATA_W] <= ramp_q[int'(cfg_o[2:0])*DATA_W +: DATA_W] + 1'b1;
    end
`else
    assign src = ch_data_i;
`endif

    assign ch_n       = {cmd_sr[1:0], din_s};
    assign src_sh     = src >> (int'(ch_n) * DATA_W);
    assign sel_sample = (int'(ch_n) < NUM_CH) ? src_sh[DATA_W-1:0] : '0;

    function automatic logic bit_at(input logic [DATA_W-1:0] v, input logic [BW-1:0] k);
        logic [DATA_W-1:0] sh;
        sh = (DATA_LSB_FIRST != 0) ? (v >> k) : (v << k);
        return (DATA_LSB_FIRST != 0) ? sh[0] : sh[DATA_W-1];
    endfunction

    // Next-state and datapath decisions; a cs rise mid-frame overrides any sclk edge
    always_comb begin
        state_n   = state;
        cmd_cnt_n = cmd_cnt;
        cmd_sr_n  = cmd_sr;
        bit_cnt_n = bit_cnt;
        sam_n     = sam;
        dout_n    = dout_o;
        done_n    = 1'b0;
        abort_n   = 1'b0;
        cfg_n     = cfg_o;
        sample_n  = sample_o;
        case (state)
            IDLE: begin
                dout_n    = 1'b0;
                cmd_cnt_n = '0;
                bit_cnt_n = '0;
                sam_n     = 1'b0;
                if (!cs_s) state_n = CMD;
            end
            CMD: if (rise) begin
                if (cmd_cnt == 3'd0) begin
                    cmd_cnt_n = din_s ? 3'd1 : 3'd0;
                end else begin
                    cmd_sr_n  = {cmd_sr[1:0], din_s};
                    cmd_cnt_n = cmd_cnt + 3'd1;
                    if (cmd_cnt == 3'd4) begin
                        cfg_n    = {cmd_sr, din_s};
                        sample_n = sel_sample;
                        state_n  = SAMPLE;
                    end
                end
            end
            SAMPLE: if (fall) begin
                dout_n = 1'b0;
                sam_n  = 1'b1;
                if (sam) state_n = NULLB;
            end
            NULLB: if (fall) begin
                dout_n    = bit_at(sample_o, '0);
                bit_cnt_n = BW'(1);
                state_n   = DATA;
            end
            DATA: begin
                if (fall && bit_cnt != LAST) begin
                    dout_n    = bit_at(sample_o, bit_cnt);
                    bit_cnt_n = bit_cnt + 1'b1;
                end else if (rise && bit_cnt == LAST) begin
                    done_n  = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                dout_n = 1'b0;
                if (cs_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (cs_s && (state == CMD || state == SAMPLE || state == NULLB || state == DATA)) begin
            state_n = IDLE;
            dout_n  = 1'b0;
            done_n  = 1'b0;
            abort_n = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            cmd_cnt       <= '0;
            cmd_sr        <= '0;
            bit_cnt       <= '0;
            sam           <= 1'b0;
            dout_o        <= 1'b0;
            frame_done_o  <= 1'b0;
            frame_abort_o <= 1'b0;
            cfg_o         <= '0;
            sample_o      <= '0;
        end else begin
            state         <= state_n;
            cmd_cnt       <= cmd_cnt_n;
            cmd_sr        <= cmd_sr_n;
            bit_cnt       <= bit_cnt_n;
            sam           <= sam_n;
            dout_o        <= dout_n;
            frame_done_o  <= done_n;
            frame_abort_o <= abort_n;
            cfg_o         <= cfg_n;
            sample_o      <= sample_n;
        end
    end
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: randomized frames against a frame-level model of the emulated ADC
module tb_adc_spi_responder;
    localparam int NUM_CH = 6;
    localparam int DATA_W = 10;
    localparam int LSB    = 1;
    localparam int SS     = 2;
    localparam int HALF   = 8;

    logic clk_i = 1'b0, rst_n_i = 1'b0, sclk_i = 1'b0, cs_i = 1'b1, din_i = 1'b0;
    logic [NUM_CH*DATA_W-1:0] ch_data_i = '0;
    logic dout_o, busy_o, frame_done_o, frame_abort_o;
    logic [3:0] cfg_o;
    logic [DATA_W-1:0] sample_o;

    int n_checks = 0, n_pass = 0, n_done = 0, n_abort = 0;
    logic [DATA_W-1:0] model_data [NUM_CH];
    int ramp_cnt [NUM_CH];

    always #5 clk_i = ~clk_i;

    adc_spi_responder #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DATA_LSB_FIRST(LSB), .SYNC_STAGES(SS)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .sclk_i(sclk_i), .cs_i(cs_i), .din_i(din_i),
        .dout_o(dout_o), .ch_data_i(ch_data_i), .busy_o(busy_o), .frame_done_o(frame_done_o),
        .frame_abort_o(frame_abort_o), .cfg_o(cfg_o), .sample_o(sample_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DATA_W-1:0] exp_sample(input logic [2:0] ch);
        if (int'(ch) >= NUM_CH) return '0;
`ifdef ADC_EMU_RAMP_EN
        return DATA_W'(ramp_cnt[ch]);
`else
        return model_data[ch];
`endif
    endfunction

    task automatic set_data(input int ch, input logic [DATA_W-1:0] v);
        model_data[ch] = v;
        ch_data_i[ch*DATA_W +: DATA_W] = v;
    endtask

    // Pulse counting and the idle invariant, checked every cycle
    always @(negedge clk_i) begin
        if (frame_done_o) n_done++;
        if (frame_abort_o) n_abort++;
        if (!busy_o) check("idle_dout", {31'd0, dout_o}, 32'd0);
    end

    task automatic wait_half();
        repeat (HALF) @(negedge clk_i);
    endtask

    task automatic send_bit(input logic b, output logic d);
        din_i = b;
        wait_half();
        d = dout_o;
        sclk_i = 1'b1;
        wait_half();
        sclk_i = 1'b0;
    endtask

    task automatic run_frame(input int lead, input logic sgl, input logic [2:0] ch, input int nread,
                             output logic [DATA_W-1:0] word);
        logic d;
        logic [DATA_W-1:0] e;
        int d0, a0, idx;
        bit full;
        d0 = n_done;
        a0 = n_abort;
        full = (nread >= DATA_W + 2);
        e = exp_sample(ch);
        word = '0;
        cs_i = 1'b0;
        wait_half();
        for (int i = 0; i < lead; i++) send_bit(1'b0, d);
        send_bit(1'b1, d);
        send_bit(sgl, d);
        for (int j = 2; j >= 0; j--) send_bit(ch[j], d);
        for (int i = 0; i < nread; i++) begin
            send_bit(1'b0, d);
            if (i < 2) check("null_bit", {31'd0, d}, 32'd0);
            else begin
                idx = (LSB != 0) ? i - 2 : DATA_W - 1 - (i - 2);
                word[idx] = d;
                check("data_bit", {31'd0, d}, {31'd0, e[idx]});
            end
        end
        if (full) begin
            wait_half();
            check("done_pulses", n_done - d0, 1);
            check("cfg", {28'd0, cfg_o}, {28'd0, sgl, ch});
            check("sample", {22'd0, sample_o}, {22'd0, e});
            if (int'(ch) < NUM_CH) ramp_cnt[ch] = (ramp_cnt[ch] + 1) % (1 << DATA_W);
        end
        cs_i = 1'b1;
        repeat (SS + 2) @(negedge clk_i);
        check("busy_after_cs", {31'd0, busy_o}, 32'd0);
        check("dout_after_cs", {31'd0, dout_o}, 32'd0);
        check("abort_pulses", n_abort - a0, full ? 0 : 1);
        if (!full) check("no_done_on_abort", n_done - d0, 0);
        wait_half();
    endtask

    initial begin
        logic [DATA_W-1:0] w;
        logic d;
        int nr, d0, a0;
        for (int k = 0; k < NUM_CH; k++) begin
            model_data[k] = '0;
            ramp_cnt[k] = 0;
        end
        repeat (3) @(negedge clk_i);
        check("rst_busy", {31'd0, busy_o}, 0);
        check("rst_dout", {31'd0, dout_o}, 0);
        check("rst_pulses", {30'd0, frame_done_o, frame_abort_o}, 0);
        check("rst_cfg", {28'd0, cfg_o}, 0);
        check("rst_sample", {22'd0, sample_o}, 0);
        rst_n_i = 1'b1;
        repeat (4) @(negedge clk_i);
`ifdef ADC_EMU_RAMP_EN
        for (int f = 0; f < 4; f++) begin
            run_frame(0, 1'b1, 3'd2, 12, w);
            check("ramp_ch2", {22'd0, w}, f);
        end
        run_frame(0, 1'b0, 3'd5, 12, w);
        check("ramp_ch5_first", {22'd0, w}, 0);
        run_frame(0, 1'b1, 3'd2, 6, w);
        run_frame(1, 1'b1, 3'd2, 12, w);
        check("ramp_after_abort", {22'd0, w}, 4);
`else
        set_data(0, 10'h2A5);
        run_frame(0, 1'b1, 3'd0, 12, w);
        check("t1_word", {22'd0, w}, 32'h2A5);
        check("t1_cfg", {28'd0, cfg_o}, 32'b1000);
        set_data(3, 10'h3FF);
        run_frame(3, 1'b1, 3'd3, 12, w);
        check("t2_word", {22'd0, w}, 32'h3FF);
        check("t2_cfg", {28'd0, cfg_o}, 32'b1011);
        run_frame(0, 1'b0, 3'd7, 12, w);
        check("t3_word", {22'd0, w}, 0);
        check("t3_sample", {22'd0, sample_o}, 0);
        run_frame(0, 1'b1, 3'd0, 6, w);
        run_frame(0, 1'b1, 3'd0, 12, w);
        check("t4_next_word", {22'd0, w}, 32'h2A5);
`endif
        for (int n = 0; n < 30; n++) begin
`ifndef ADC_EMU_RAMP_EN
            for (int k = 0; k < NUM_CH; k++) set_data(k, DATA_W'($urandom));
`endif
            nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : 12;
            run_frame(int'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 7)), nr, w);
        end
        d0 = n_done;
        a0 = n_abort;
        cs_i = 1'b0;
        wait_half();
        send_bit(1'b1, d);
        send_bit(1'b0, d);
        send_bit(1'b0, d);
        send_bit(1'b1, d);
        send_bit(1'b0, d);
        for (int i = 0; i < 4; i++) send_bit(1'b0, d);
        #1 rst_n_i = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy_o}, 0);
        check("midrst_dout", {31'd0, dout_o}, 0);
        check("midrst_cfg", {28'd0, cfg_o}, 0);
        check("midrst_sample", {22'd0, sample_o}, 0);
        cs_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (4) @(negedge clk_i);
        check("midrst_no_pulses", (n_done - d0) + (n_abort - a0), 0);
        for (int k = 0; k < NUM_CH; k++) ramp_cnt[k] = 0;
        set_data(5, 10'h155);
        run_frame(2, 1'b1, 3'd5, 12, w);
        check("post_rst_word", {22'd0, w}, {22'd0, exp_sample(3'd5)});
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
